// File: rtl/adc_pkg.sv
// Shared defaults and geometry helpers for the capacitor-matrix DAC decoder.
// Unit cells are numbered along a serpentine path through the matrix.
package adc_pkg;

    localparam int unsigned ROWS_DEFAULT    = 16;
    localparam int unsigned COLS_DEFAULT    = 32;
    localparam int unsigned BINBITS_DEFAULT = 3;

    // Serpentine unit index -> physical row-major cell number (odd rows run right-to-left).
    function automatic int unsigned serp_to_phys(input int unsigned idx,
                                                 input int unsigned cols);
        int unsigned row;
        int unsigned col;
        row = idx / cols;
        col = idx % cols;
        if (row % 2 == 1) begin
            col = cols - 1 - col;
        end
        return row * cols + col;
    endfunction

    function automatic int unsigned serp_row(input int unsigned idx, input int unsigned cols);
        return idx / cols;
    endfunction

    function automatic int unsigned serp_col(input int unsigned idx, input int unsigned cols);
        int unsigned col;
        col = idx % cols;
        if ((idx / cols) % 2 == 1) begin
            col = cols - 1 - col;
        end
        return col;
    endfunction

endpackage

// File: rtl/adc_dwa_rotator.sv
// Builds a thermometer of `units` enabled cells and rotates it to start at `ptr`.
// Output is active-high (1 = cell enabled), indexed by serpentine position.
module adc_dwa_rotator #(
    parameter int unsigned NU = 512,
    parameter int unsigned UW = 9
) (
    input  logic [UW:0]   units,
    input  logic [UW-1:0] ptr,
    output logic [NU-1:0] mask
);

    logic [NU-1:0]   therm;
    logic [2*NU-1:0] doubled;

    always_comb begin
        therm = '0;
        for (int i = 0; i < int'(NU); i++) begin
            therm[i] = (i < int'(units));
        end
    end

    // Rotate-left by ptr: the upper half of the shifted doubled word wraps cleanly.
    always_comb begin
        doubled = {therm, therm} << ptr;
        mask    = doubled[2*NU-1:NU];
    end

endmodule

// File: rtl/adc_cap_matrix_dwa_decoder.sv
// Capacitor-matrix DAC decoder: unit code -> thermometer or DWA-rotated cell enables,
// binary LSB code -> binary capacitors, behind a single-stage valid/ready register.
module adc_cap_matrix_dwa_decoder
    import adc_pkg::*;
#(
    parameter int unsigned  ROWS    = ROWS_DEFAULT,
    parameter int unsigned  COLS    = COLS_DEFAULT,
    parameter int unsigned  BINBITS = BINBITS_DEFAULT,
    localparam int unsigned NU      = ROWS * COLS,
    localparam int unsigned UW      = $clog2(NU),
    localparam int unsigned DW      = UW + BINBITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      data_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               dwa_en,
    input  logic               ptr_clr,
    output logic [NU-1:0]      cell_out_n,
    output logic [BINBITS-1:0] bincap_out_n,
    output logic               c0p_out_n,
    output logic               c0n_out_n,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [UW-1:0]      ptr_out
);

    localparam logic [UW:0] NU_W = (UW + 1)'(NU);

    logic [UW-1:0]      ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [NU-1:0]      cell_q;
    logic [BINBITS-1:0] bin_q;

    logic               accept;
    logic [UW-1:0]      unit_code;
    logic [UW:0]        units_sat;
    logic [UW-1:0]      ptr_base;
    logic [UW:0]        ptr_sum;
    logic [UW:0]        ptr_wrap;
    logic [UW-1:0]      ptr_adv;
    logic [NU-1:0]      cell_mask;

    assign in_ready = rst_n & (~valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    assign unit_code = data_in[DW-1:BINBITS];

    // Codes above NU (only possible when NU is not a power of two) saturate to all cells.
    always_comb begin
        units_sat = {1'b0, unit_code};
        if ({1'b0, unit_code} >= NU_W) begin
            units_sat = NU_W;
        end
    end

    // A coincident ptr_clr makes the sample start from cell 0; thermometer mode always does.
    assign ptr_base = (ptr_clr || !dwa_en) ? '0 : ptr_q;

    always_comb begin
        ptr_sum  = {1'b0, ptr_base} + units_sat;
        ptr_wrap = ptr_sum;
        if (ptr_sum >= NU_W) begin
            ptr_wrap = ptr_sum - NU_W;
        end
        ptr_adv = UW'(ptr_wrap);
    end

    adc_dwa_rotator #(
        .NU (NU),
        .UW (UW)
    ) u_rotator (
        .units (units_sat),
        .ptr   (ptr_base),
        .mask  (cell_mask)
    );

    always_comb begin
        ptr_d = ptr_q;
        if (accept && dwa_en) begin
            ptr_d = ptr_adv;
        end else if (ptr_clr) begin
            ptr_d = '0;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output data only moves on acceptance, so it holds under backpressure and after drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ptr_q   <= '0;
            cell_q  <= '1;
            bin_q   <= '1;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                cell_q <= ~cell_mask;
                bin_q  <= ~data_in[BINBITS-1:0];
            end
        end
    end

    assign cell_out_n   = cell_q;
    assign bincap_out_n = bin_q;
    assign out_valid    = valid_q;
    assign ptr_out      = ptr_q;
    assign c0p_out_n    = 1'b0;
    assign c0n_out_n    = 1'b1;

    ptr_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, ptr_q} < NU_W);

    hold_under_backpressure: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && !out_ready) |=> ($stable(cell_q) && $stable(bin_q)));

endmodule

// File: tb/tb_adc_cap_matrix_dwa_decoder.sv
// Randomized scoreboard bench for the capacitor-matrix DWA decoder with directed corner cases.
module tb_adc_cap_matrix_dwa_decoder;

    localparam int unsigned ROWS    = 16;
    localparam int unsigned COLS    = 32;
    localparam int unsigned BINBITS = 3;
    localparam int unsigned NU      = ROWS * COLS;
    localparam int unsigned UW      = 9;
    localparam int unsigned DW      = UW + BINBITS;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DW-1:0]      data_in = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               dwa_en = 1'b0;
    logic               ptr_clr = 1'b0;
    logic [NU-1:0]      cell_out_n;
    logic [BINBITS-1:0] bincap_out_n;
    logic               c0p_out_n;
    logic               c0n_out_n;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [UW-1:0]      ptr_out;

    adc_cap_matrix_dwa_decoder #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .BINBITS (BINBITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .dwa_en       (dwa_en),
        .ptr_clr      (ptr_clr),
        .cell_out_n   (cell_out_n),
        .bincap_out_n (bincap_out_n),
        .c0p_out_n    (c0p_out_n),
        .c0n_out_n    (c0n_out_n),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ptr_out      (ptr_out)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [NU-1:0]      cells;
        logic [BINBITS-1:0] bin;
    } exp_t;

    exp_t        q[$];
    exp_t        last;
    exp_t        m_e;
    int          tests = 0;
    int          fails = 0;
    bit          armed = 1'b0;
    bit          mvalid = 1'b0;
    bit          m_rdy;
    int unsigned mptr = 0;
    int unsigned m_u;
    int unsigned m_p;
    int          ready_mode = 0;

    task automatic chk(input string name, input logic [NU-1:0] act, input logic [NU-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: cells enabled are the u consecutive serpentine slots starting at p (mod NU).
    function automatic logic [NU-1:0] model_cells(input int unsigned u, input int unsigned p,
                                                  input bit dwa);
        logic [NU-1:0] v;
        v = '1;
        for (int unsigned k = 0; k < u && k < NU; k++) begin
            v[dwa ? (p + k) % NU : k] = 1'b0;
        end
        return v;
    endfunction

    // Output-ready pattern generator.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Reference model: tracks handshake, pointer and pushes expected outputs on acceptance.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                chk("in_ready_in_reset", NU'(in_ready), '0);
                q.delete();
                mvalid     = 1'b0;
                mptr       = 0;
                last.cells = '1;
                last.bin   = '1;
                armed      = 1'b1;
            end else if (armed) begin
                m_rdy = !mvalid || out_ready;
                chk("in_ready", NU'(in_ready), NU'(m_rdy));
                chk("out_valid", NU'(out_valid), NU'(mvalid));
                chk("ptr_out", NU'(ptr_out), NU'(mptr));
                chk("c0_ties", NU'({c0p_out_n, c0n_out_n}), NU'(2'b01));
                if (in_valid && m_rdy) begin
                    m_u       = int'(data_in[DW-1:BINBITS]);
                    m_p       = ptr_clr ? 0 : mptr;
                    m_e.cells = model_cells(m_u, m_p, dwa_en);
                    m_e.bin   = ~data_in[BINBITS-1:0];
                    q.push_back(m_e);
                    if (dwa_en) mptr = (m_p + m_u) % NU;
                    else if (ptr_clr) mptr = 0;
                    mvalid = 1'b1;
                end else begin
                    if (ptr_clr) mptr = 0;
                    if (out_ready) mvalid = 1'b0;
                end
            end
        end
    end

    // Monitor: compares presented outputs against the scoreboard, pops on transfer.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (armed && rst_n) begin
                if (out_valid === 1'b1) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_out_valid: got out_valid=1 required 0 (none pending)");
                    end else begin
                        chk("cells", cell_out_n, q[0].cells);
                        chk("bincap", NU'(bincap_out_n), NU'(q[0].bin));
                        if (out_ready) last = q.pop_front();
                    end
                end else begin
                    chk("idle_cells", cell_out_n, last.cells);
                    chk("idle_bincap", NU'(bincap_out_n), NU'(last.bin));
                end
            end
        end
    end

    task automatic send(input int unsigned u, input int unsigned b, input bit dwa, input bit clr);
        logic [UW-1:0]      uu;
        logic [BINBITS-1:0] bb;
        bit                 acc;
        uu = u[UW-1:0];
        bb = b[BINBITS-1:0];
        @(negedge clk);
        in_valid = 1'b1;
        data_in  = {uu, bb};
        dwa_en   = dwa;
        ptr_clr  = clr;
        acc      = 1'b0;
        for (int n = 0; n < 200 && !acc; n++) begin
            #6;
            if (in_ready) acc = 1'b1;
            else @(negedge clk);
        end
        if (acc) begin
            @(posedge clk);
            #1;
        end else begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles required 1");
        end
        in_valid = 1'b0;
        ptr_clr  = 1'b0;
    endtask

    task automatic idle_cycle(input bit clr);
        @(negedge clk);
        in_valid = 1'b0;
        ptr_clr  = clr;
        @(posedge clk);
        #1;
        ptr_clr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    logic [NU-1:0]   e;
    logic [COLS-1:0] row_en [ROWS];
    int unsigned     ru;
    int              qs;

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Thermometer u=3, bin=5.
        send(3, 5, 1'b0, 1'b0);
        e = '1;
        for (int i = 0; i < 3; i++) e[i] = 1'b0;
        chk("t038_cells", cell_out_n, e);
        chk("t038_bincap", NU'(bincap_out_n), NU'(3'b010));
        chk("t038_ptr", NU'(ptr_out), '0);

        // DWA spans 0, 100, 300 with wrap.
        send(100, 0, 1'b1, 1'b0);
        send(200, 0, 1'b1, 1'b0);
        send(300, 0, 1'b1, 1'b0);
        e = '1;
        for (int i = 300; i < 512; i++) e[i] = 1'b0;
        for (int i = 0; i < 88; i++) e[i] = 1'b0;
        chk("t039_cells", cell_out_n, e);
        chk("t039_ptr", NU'(ptr_out), NU'(88));

        // Backpressure for several cycles with pending input.
        ready_mode = 2;
        fork
            begin
                repeat (6) @(negedge clk);
                ready_mode = 0;
            end
            begin
                send(5, 1, 1'b1, 1'b0);
                send(6, 2, 1'b1, 1'b0);
                send(7, 3, 1'b1, 1'b0);
            end
        join

        // ptr_clr coincident with a DWA sample at pointer 400.
        send(0, 0, 1'b0, 1'b1);
        send(400, 0, 1'b1, 1'b0);
        chk("t041_ptr_pre", NU'(ptr_out), NU'(400));
        send(10, 0, 1'b1, 1'b1);
        e = '1;
        for (int i = 0; i < 10; i++) e[i] = 1'b0;
        chk("t041_cells", cell_out_n, e);
        chk("t041_ptr", NU'(ptr_out), NU'(10));

        // Serpentine reversal on row 1.
        send(34, 0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < NU; i++) begin
            if ((i / COLS) % 2 == 1) row_en[i / COLS][COLS - 1 - (i % COLS)] = !cell_out_n[i];
            else                     row_en[i / COLS][i % COLS]            = !cell_out_n[i];
        end
        chk("t042_row0", NU'(row_en[0]), NU'(32'hFFFF_FFFF));
        chk("t042_row1", NU'(row_en[1]), NU'(32'hC000_0000));
        chk("t042_row2", NU'(row_en[2]), '0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            if (n == 0)   ready_mode = 1;
            if (n == 150) ready_mode = 0;
            if ($urandom_range(0, 9) == 0) idle_cycle(1'($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0:       ru = 0;
                1:       ru = NU - 1;
                2:       ru = $urandom_range(0, NU - 1);
                default: ru = $urandom_range(1, 8);
            endcase
            send(ru, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0));
        end

        // Reset while a held output is valid and the pointer is nonzero.
        ready_mode = 0;
        repeat (4) @(negedge clk);
        ready_mode = 2;
        send(50, 4, 1'b1, 1'b1);
        chk("t043_ptr_pre", NU'(ptr_out), NU'(50));
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        data_in  = {9'd77, 3'd1};
        dwa_en   = 1'b1;
        @(posedge clk);
        #1;
        chk("t043_out_valid", NU'(out_valid), '0);
        chk("t043_cells", cell_out_n, '1);
        chk("t043_bincap", NU'(bincap_out_n), NU'(3'b111));
        chk("t043_ptr", NU'(ptr_out), '0);
        @(negedge clk);
        in_valid   = 1'b0;
        dwa_en     = 1'b0;
        rst_n      = 1'b1;
        ready_mode = 0;
        send(2, 6, 1'b1, 1'b0);

        repeat (5) @(negedge clk);
        qs = q.size();
        chk("drain_queue_empty", NU'(qs), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_cap_matrix_dwa_decoder.md
ADC_CAP_MATRIX_DWA_DECODER -- requirements
Module: adc_cap_matrix_dwa_decoder

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of unit-cell rows in the capacitor matrix.
REQ-002 SHALL have parameter COLS, default 32, number of unit cells per row.
REQ-003 SHALL have parameter BINBITS, default 3, number of binary-weighted LSB capacitors.
REQ-004 SHALL derive the following local parameters, not overridable:
- NU = ROWS*COLS
- UW = clog2(NU)
- DW = UW+BINBITS, which is 12 at the defaults.
REQ-005 SHALL have port clk, input, 1 bit: the block's single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port data_in, input, DW bits: DAC code, with the unit code in [DW-1:BINBITS] and the binary code in [BINBITS-1:0].
REQ-008 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: input handshake.
REQ-009 SHALL have port dwa_en, input, 1 bit: 1 selects data-weighted-averaging rotation, 0 selects plain thermometer mode.
REQ-010 SHALL have port ptr_clr, input, 1 bit: synchronous clear of the rotation pointer.
REQ-011 SHALL have port cell_out_n, output, NU bits: active-low unit-cell enables, indexed by serpentine position.
REQ-012 SHALL have port bincap_out_n, output, BINBITS bits: active-low binary-capacitor enables.
REQ-013 SHALL have port c0p_out_n, output, 1 bit, tied to constant 0, and port c0n_out_n, output, 1 bit, tied to constant 1.
REQ-014 SHALL have port out_valid, input-side-paired output, 1 bit, and port out_ready, input, 1 bit: output handshake.
REQ-015 SHALL have port ptr_out, output, UW bits: current rotation pointer, for observability.

Function
REQ-016 SHALL accept a sample on every rising clk edge where in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready = ~out_valid | out_ready, giving a single-stage pipeline with no bubble under continuous flow.
REQ-018 SHALL register an accepted sample into cell_out_n and bincap_out_n with 1-cycle latency, and set out_valid=1 on the same edge.
REQ-019 SHALL clear out_valid when out_valid=1, out_ready=1, and no new sample is accepted on that edge.
REQ-020 SHALL hold cell_out_n and bincap_out_n stable while out_valid=1 and out_ready=0.
REQ-021 SHALL hold cell_out_n and bincap_out_n at their last value after out_valid falls; they SHALL NOT return to the reset value.
REQ-022 SHALL map each serpentine unit index i to a physical cell as follows:
- row r = i/COLS
- column c = i%COLS on even rows, COLS-1-(i%COLS) on odd rows.
REQ-023 SHALL set bincap_out_n = ~data_in[BINBITS-1:0] for each accepted sample.
REQ-024 SHALL, when dwa_en=0, set cell_out_n[i]=0 exactly for i < u, where u is the unit code, and leave the pointer unchanged.
REQ-025 SHALL, when dwa_en=1, set cell_out_n[(p+k) mod NU]=0 for k = 0..u-1, where p is the pointer; all other cells SHALL be 1.
REQ-026 SHALL, after an accepted sample with dwa_en=1, update the pointer to p ← (p+u) mod NU, with wrap-around past NU-1.
REQ-027 SHALL, for u=0, enable no unit cells and leave the pointer unchanged.
REQ-028 SHALL clear the pointer to 0 on the next edge when ptr_clr=1 and no sample is accepted on that edge.
REQ-029 SHALL, when ptr_clr=1 coincides with an accepted sample with dwa_en=1, use p=0 for that sample and set the pointer to u.
REQ-030 SHALL, when ptr_clr=1 coincides with an accepted sample with dwa_en=0, decode that sample normally and clear the pointer to 0.
REQ-031 SHALL sample dwa_en per accepted sample, so modes may be switched sample-to-sample without flushing.

Reset
REQ-032 SHALL, on a clk edge with rst_n=0, set out_valid=0, pointer=0, cell_out_n all 1, and bincap_out_n all 1.
REQ-033 SHALL hold in_ready=0 while rst_n=0.
REQ-034 SHALL discard any sample presented or held when reset is asserted mid-operation; no partial pointer update SHALL occur.

Structure
REQ-035 SHALL place the default values of ROWS, COLS, and BINBITS, and the serpentine-index helper function, in the shared package adc_pkg.
REQ-036 SHALL implement the thermometer-generate-and-rotate logic (u, p → NU-bit mask) in a combinational sub-module named adc_dwa_rotator.
REQ-037 SHALL keep all state (pointer, output registers, out_valid) in the top module.

Verification
REQ-038 SHALL verify: after reset, with dwa_en=0 and data_in=12'h01D (u=3, bin=5) → one cycle later, cells 0..2 low, bincap_out_n=3'b010, ptr_out=0.
REQ-039 SHALL verify: with dwa_en=1, codes u=100, 200, 300 in sequence → enabled spans start at 0, 100, and 300; the third sample's cells are 300..511 and 0..87; ptr_out ends at 88.
REQ-040 SHALL verify: with out_ready=0 for 5 cycles and in_valid=1 → in_ready=0, outputs frozen, pointer unchanged; on release, one sample per cycle resumes.
REQ-041 SHALL verify: ptr_clr=1 together with an accepted sample u=10, dwa_en=1, pointer=400 → cells 0..9 low and ptr_out=10.
REQ-042 SHALL verify: on row 1 (i=32..63), u=34 with dwa_en=0 → physical columns 31 and 30 of row 1 enabled (serpentine reversal).
REQ-043 SHALL verify: rst_n=0 asserted while out_valid=1 and the pointer is nonzero → the next cycle shows all outputs at reset values and ptr_out=0.
